clk_div_bank: RTL
=================

# clk_div_bank

Multi-channel, runtime-programmable clock generator driven from the board reference clock. It produces NUM_CH registered square-wave outputs with per-channel integer divide ratio, high time and phase offset, plus a global lock indication. It sits beside the fixed-ratio PLL wrappers and supplies low-rate derived clocks and matching rising-edge enables, for example 12 MHz-class codec or LED timing. Its channels can be reprogrammed and re-aligned without a device reconfiguration.

## Interface
- NUM_CH, default 2: number of output channels, legal range 1..8.
- CNT_W, default 16: width of the divide, high and phase fields.
- DEF_DIV, default 4: divide ratio loaded into every channel at reset.
- DEF_HIGH, default 2: high time, in refclk cycles, loaded into every channel at reset.
- LOCK_CYCLES, default 8: settle length before `locked` asserts, legal range ≥1.
- `refclk`, in, 1: single clock.
- `rst`, in, 1: reset. **Synchronous, active-high.**
- `cfg_valid`, in, 1: write request for the shadow registers of channel `cfg_ch`.
- `cfg_ch`, in, max(1,$clog2(NUM_CH)): target channel.
- `cfg_div`, in, CNT_W: period in refclk cycles.
- `cfg_high`, in, CNT_W: high time in refclk cycles.
- `cfg_phase`, in, CNT_W: rising-edge delay in refclk cycles.
- `cfg_apply`, in, 1: copy all shadow registers to the active registers and re-align all channels.
- `cfg_ready`, out, 1: configuration write and apply are accepted.
- `cfg_err`, out, 1: one-cycle pulse when an accepted write was clamped.
- `outclk`, out, NUM_CH: registered divided clocks.
- `outclk_rise`, out, NUM_CH: one-cycle pulse in the first high cycle of each `outclk` period.
- `locked`, out, 1: all channels are running and phase-aligned.

## Operation
- **Per-channel state:**
  - Shadow registers: div_s, high_s, phase_s.
  - Active registers: div_a, high_a, phase_a.
  - Counter: cnt, of width CNT_W.
- **Reset values:**
  - Shadow and active registers: div = DEF_DIV, high = DEF_HIGH, phase = 0.
  - cnt = 0.
  - Outputs: `outclk` = 0, `outclk_rise` = 0, `locked` = 0, `cfg_ready` = 0, `cfg_err` = 0.
- **FSM states:** SETTLE and LOCKED. Reset enters SETTLE with lock_cnt = 0.
- **SETTLE:**
  - lock_cnt increments each cycle. When lock_cnt == LOCK_CYCLES-1, the next state is LOCKED.
  - cnt is held at 0, `outclk` and `outclk_rise` are forced to 0, and `cfg_ready` = 0.
- **LOCKED:**
  - `locked` = 1 and `cfg_ready` = 1.
  - Each cnt counts 0..div_a-1 and then wraps to 0.
- **Output equation:**
  - pos = (cnt ≥ phase_a) ? cnt−phase_a : cnt+div_a−phase_a.
  - The next `outclk` = (pos < high_a).
  - The next `outclk_rise` = (pos == 0) && (high_a ≥ 1).
- **Write** (`cfg_valid` && `cfg_ready`):
  - Updates the shadow registers of channel `cfg_ch` only. The active registers are unchanged and the outputs are undisturbed.
  - A `cfg_ch` ≥ NUM_CH is dropped and pulses `cfg_err`.
- **Clamping on write:**
  - div < 2 becomes 2.
  - high == 0 becomes 1.
  - high ≥ div becomes div−1 (using the clamped div).
  - phase ≥ div becomes 0.
  - Any clamp pulses `cfg_err` in the cycle after the write.
- **Apply** (`cfg_apply` && `cfg_ready`):
  - Copies shadow to active for all channels.
  - Moves the FSM to SETTLE and clears lock_cnt. `locked` drops in the next cycle.
- **Simultaneous write and apply in the same cycle:** the write lands in the shadow first and is included in the apply.
- **Writes or applies while `cfg_ready` = 0:** ignored, with no `cfg_err`.
- **`rst` in any state, including mid-SETTLE:** full reset to the reset values above. Shadow contents are lost.

## Timing
- Cycle 0 is the first edge with `rst` low.
- `locked` and `cfg_ready` first read 1 after edge LOCK_CYCLES−1, that is, in cycle LOCK_CYCLES. cnt = 0 in that cycle.
- `outclk` latency from cnt is one register. A channel with phase 0 shows its first high cycle, with `outclk_rise` = 1, one cycle after `locked` rises.
- Channel phase p rises p cycles after a phase-0 channel with the same div. All channels are re-aligned after every apply.
- The `outclk` period is exactly div_a cycles, with high_a cycles high. No glitches: `outclk` changes at most twice per period.
- `cfg_err` appears one cycle after the accepted write.

## Test plan
- **Reset defaults:** NUM_CH=2, LOCK_CYCLES=8, release `rst` → `locked`=1 in cycle 8. Both channels then toggle with 2 cycles high and 2 low, and `outclk_rise` pulses every 4 cycles starting in cycle 9.
- **Write then apply:** write ch1 div=5, high=2, phase=3, then apply → `locked` low for 8 cycles. ch1 rising edges then land 3 cycles after ch0's, with a period of 5.
- **Clamping:** write div=1, high=0 → `cfg_err` pulse; after apply, div=2 and high=1. Write div=6, high=9, phase=7 → `cfg_err`; active values become high=5, phase=0.
- **Write without apply:** write with no apply → outputs unchanged for 100 cycles. Writes and applies during SETTLE are ignored, with no `cfg_err`.
- **Simultaneous write and apply:** `cfg_valid` and `cfg_apply` in the same cycle → the new ch0 value is active after the settle.
- **Reset mid-operation:** `rst` mid-SETTLE and mid-LOCKED → all outputs 0 in the next cycle, defaults restored, and `locked` returns 8 cycles after release.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock divider with shadowed configuration,
// synchronous re-alignment on apply, and a global lock indication.
module clk_div_bank #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEF_DIV     = 4,
    parameter int unsigned DEF_HIGH    = 2,
    parameter int unsigned LOCK_CYCLES = 8,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              cfg_apply,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_rise,
    output logic              locked
);

    localparam int unsigned LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LK_W-1:0]   lock_cnt;
    logic              wr_acc;
    logic              ap_acc;
    logic              ch_ok;
    logic              run_c;
    logic [CNT_W-1:0]  div_c;
    logic [CNT_W-1:0]  high_c;
    logic [CNT_W-1:0]  phase_c;
    logic              clamp_c;
    logic [NUM_CH-1:0] clk_raw;
    logic [NUM_CH-1:0] rise_raw;
    logic [NUM_CH-1:0] outclk_d;
    logic [NUM_CH-1:0] rise_d;
    logic              locked_d;
    logic              err_d;

    assign wr_acc = cfg_valid && cfg_ready;
    assign ap_acc = cfg_apply && cfg_ready;
    assign ch_ok  = (32'(cfg_ch) < NUM_CH);
    // Channels run only while locked and not being re-aligned this cycle
    assign run_c  = (state == LOCKED) && (state_next == LOCKED);

    // Clamp the incoming write to a legal divide/high/phase triple
    always_comb begin
        div_c   = cfg_div;
        high_c  = cfg_high;
        phase_c = cfg_phase;
        clamp_c = 1'b0;
        if (cfg_div < CNT_W'(2)) begin
            div_c   = CNT_W'(2);
            clamp_c = 1'b1;
        end
        if (cfg_high == '0) begin
            high_c  = CNT_W'(1);
            clamp_c = 1'b1;
        end
        if (high_c >= div_c) begin
            high_c  = div_c - CNT_W'(1);
            clamp_c = 1'b1;
        end
        if (cfg_phase >= div_c) begin
            phase_c = '0;
            clamp_c = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] div_s, high_s, phase_s;
        logic [CNT_W-1:0] div_a, high_a, phase_a;
        logic [CNT_W-1:0] div_n, high_n, phase_n;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] pos;
        logic             sel;

        assign sel = wr_acc && ch_ok && (cfg_ch == CH_W'(g));

        // Shadow values including a write landing this cycle
        always_comb begin
            div_n   = div_s;
            high_n  = high_s;
            phase_n = phase_s;
            if (sel) begin
                div_n   = div_c;
                high_n  = high_c;
                phase_n = phase_c;
            end
        end

        // Shadow and active configuration registers
        always_ff @(posedge refclk) begin
            if (rst) begin
                div_s   <= CNT_W'(DEF_DIV);
                high_s  <= CNT_W'(DEF_HIGH);
                phase_s <= '0;
                div_a   <= CNT_W'(DEF_DIV);
                high_a  <= CNT_W'(DEF_HIGH);
                phase_a <= '0;
            end else begin
                div_s   <= div_n;
                high_s  <= high_n;
                phase_s <= phase_n;
                if (ap_acc) begin
                    div_a   <= div_n;
                    high_a  <= high_n;
                    phase_a <= phase_n;
                end
            end
        end

        // Period counter, held at zero outside the running state
        always_ff @(posedge refclk) begin
            if (rst || !run_c) begin
                cnt <= '0;
            end else if (cnt >= div_a - CNT_W'(1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        // Position within the phase-shifted period
        always_comb begin
            if (cnt >= phase_a) begin
                pos = cnt - phase_a;
            end else begin
                pos = cnt + div_a - phase_a;
            end
        end

        assign clk_raw[g]  = (pos < high_a);
        assign rise_raw[g] = (pos == '0) && (high_a != '0);
    end

    // State register
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= SETTLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            SETTLE: if (lock_cnt == LK_W'(LOCK_CYCLES - 1)) state_next = LOCKED;
            LOCKED: if (ap_acc) state_next = SETTLE;
            default: state_next = SETTLE;
        endcase
    end

    // Output next-values
    always_comb begin
        locked_d = (state_next == LOCKED);
        err_d    = wr_acc && (!ch_ok || clamp_c);
        outclk_d = run_c ? clk_raw : '0;
        rise_d   = run_c ? rise_raw : '0;
    end

    // Settle counter, counts only while staying in SETTLE
    always_ff @(posedge refclk) begin
        if (rst || state != SETTLE || state_next != SETTLE) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt + LK_W'(1);
        end
    end

    // Output registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            locked      <= 1'b0;
            cfg_ready   <= 1'b0;
            cfg_err     <= 1'b0;
            outclk      <= '0;
            outclk_rise <= '0;
        end else begin
            locked      <= locked_d;
            cfg_ready   <= locked_d;
            cfg_err     <= err_d;
            outclk      <= outclk_d;
            outclk_rise <= rise_d;
        end
    end

endmodule
